// File: rtl/npc_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer for the NPC core.
// Holds the instruction register and issues registered one-cycle strobes per stage.
module npc_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  input  logic             imem_rvalid_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ready_i,
  output logic             pc_we_o,
  output logic             rf_we_o,
  output logic             halt_o,
  output logic [1:0]       halt_code_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0]  OP_EBREAK = 7'b1110011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  localparam logic [1:0] HC_NONE   = 2'b00;
  localparam logic [1:0] HC_EBREAK = 2'b01;
  localparam logic [1:0] HC_ITMO   = 2'b10;
  localparam logic [1:0] HC_DTMO   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH, S_IWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_e;

  state_e             state_q;
  logic [31:0]        ir_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [CNT_W-1:0]   retired_q;
  logic               imem_req_q, inst_valid_q, dmem_req_q, dmem_we_q;
  logic               pc_we_q, rf_we_q, halt_q;
  logic [1:0]         halt_code_q;

  logic [6:0] opcode;
  logic       is_store, is_mem, wb_rf_we;

  assign opcode   = ir_q[6:0];
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_store || (opcode == OP_LOAD);
  assign wb_rf_we = !(is_store || (opcode == OP_BRANCH));

  // Strobes are registered alongside the state they belong to, so each is
  // high exactly while the FSM sits in the matching state. The single FETCH
  // cycle after reset has imem_req low; FETCH raises it and then moves on.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_FETCH;
      ir_q         <= NOP;
      wait_q       <= '0;
      retired_q    <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      pc_we_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      halt_q       <= 1'b0;
      halt_code_q  <= HC_NONE;
    end else begin
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      pc_we_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (imem_req_q) begin
            state_q <= S_IWAIT;
            wait_q  <= '0;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        S_IWAIT: begin
          if (imem_rvalid_i) begin
            ir_q         <= imem_rdata_i;
            inst_valid_q <= 1'b1;
            state_q      <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            halt_q      <= 1'b1;
            halt_code_q <= HC_ITMO;
            state_q     <= S_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (opcode == OP_EBREAK) begin
            halt_q      <= 1'b1;
            halt_code_q <= HC_EBREAK;
            state_q     <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            dmem_req_q <= 1'b1;
            dmem_we_q  <= is_store;
            state_q    <= S_MEM;
          end else begin
            pc_we_q <= 1'b1;
            rf_we_q <= wb_rf_we;
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          wait_q  <= '0;
          state_q <= S_MWAIT;
        end
        S_MWAIT: begin
          // A handshake on the final allowed cycle still completes normally.
          if (dmem_ready_i) begin
            pc_we_q <= 1'b1;
            rf_we_q <= wb_rf_we;
            state_q <= S_WB;
          end else if (wait_q == WAIT_LAST) begin
            halt_q      <= 1'b1;
            halt_code_q <= HC_DTMO;
            state_q     <= S_HALT;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired_q  <= retired_q + CNT_W'(1);
          imem_req_q <= 1'b1;
          state_q    <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  assign imem_req_o   = imem_req_q;
  assign inst_o       = ir_q;
  assign inst_valid_o = inst_valid_q;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_we_q;
  assign pc_we_o      = pc_we_q;
  assign rf_we_o      = rf_we_q;
  assign halt_o       = halt_q;
  assign halt_code_o  = halt_code_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl: cycle-indexed stimulus per instruction,
// hand-computed strobe timing, timeout boundaries and counter wrap.
module tb_npc_seq_ctrl;

  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] SW     = 32'h0010_a023;
  localparam logic [31:0] LW     = 32'h0000_a083;
  localparam logic [31:0] BEQ    = 32'h0000_0063;
  localparam logic [31:0] JAL    = 32'h0000_006f;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_rvalid, inst_valid, dmem_req, dmem_we, dmem_ready;
  logic        pc_we, rf_we, halt;
  logic [31:0] imem_rdata, inst;
  logic [1:0]  halt_code;
  logic [3:0]  retired;

  int errors = 0;
  int checks = 0;
  int n_ireq, n_iv, n_pc, n_rf, n_dreq, n_dwe, iv_at, pc_at, dreq_at;

  always #5 clk = ~clk;

  npc_seq_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .inst_o(inst), .inst_valid_o(inst_valid),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
    .pc_we_o(pc_we), .rf_we_o(rf_we),
    .halt_o(halt), .halt_code_o(halt_code), .retired_o(retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_rvalid = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
    tick();
    rst = 1'b0;
  endtask

  // Cycle 0 is the imem_req cycle; handshakes are driven on cycle i_at / d_at.
  task automatic run(input logic [31:0] w, input int i_at, input int d_at, input int n);
    n_ireq = 0; n_iv = 0; n_pc = 0; n_rf = 0; n_dreq = 0; n_dwe = 0;
    iv_at = -1; pc_at = -1; dreq_at = -1;
    for (int k = 0; k < n; k++) begin
      imem_rvalid = (k == i_at);
      imem_rdata  = w;
      dmem_ready  = (k == d_at);
      if (imem_req) n_ireq++;
      if (inst_valid) begin n_iv++; if (iv_at < 0) iv_at = k; end
      if (pc_we) begin n_pc++; if (pc_at < 0) pc_at = k; end
      if (rf_we) n_rf++;
      if (dmem_req) begin
        n_dreq++;
        if (dmem_we) n_dwe++;
        if (dreq_at < 0) dreq_at = k;
      end
      tick();
    end
    imem_rvalid = 1'b0;
    dmem_ready  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got=%b exp=0", imem_req); end
    checks++; if (inst !== 32'h13) begin errors++; $display("FAIL reset_inst got=%h exp=00000013", inst); end
    checks++; if ({inst_valid, dmem_req, pc_we, rf_we} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {inst_valid, dmem_req, pc_we, rf_we}); end
    checks++; if ({halt, halt_code} !== 3'b000) begin errors++; $display("FAIL reset_halt got=%b exp=000", {halt, halt_code}); end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_first_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_addi();
    run(ADDI, 1, -1, 5);
    checks++; if (iv_at !== 2) begin errors++; $display("FAIL addi_iv_cycle got=%0d exp=2", iv_at); end
    checks++; if (inst !== ADDI) begin errors++; $display("FAIL addi_ir got=%h exp=%h", inst, ADDI); end
    checks++; if (pc_at !== 4 || n_pc !== 1) begin errors++; $display("FAIL addi_pc_we at=%0d n=%0d exp at=4 n=1", pc_at, n_pc); end
    checks++; if (n_rf !== 1) begin errors++; $display("FAIL addi_rf_we got=%0d exp=1", n_rf); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL addi_next_req_c5 got=%b exp=1", imem_req); end
    checks++; if (retired !== 4'd1) begin errors++; $display("FAIL addi_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_store();
    run(SW, 1, 7, 9);
    checks++; if (dreq_at !== 4 || n_dreq !== 1) begin errors++; $display("FAIL sw_dreq at=%0d n=%0d exp at=4 n=1", dreq_at, n_dreq); end
    checks++; if (n_dwe !== 1) begin errors++; $display("FAIL sw_dmem_we got=%0d exp=1", n_dwe); end
    checks++; if (n_rf !== 0) begin errors++; $display("FAIL sw_rf_we got=%0d exp=0", n_rf); end
    checks++; if (n_pc !== 1 || pc_at !== 8) begin errors++; $display("FAIL sw_pc_we n=%0d at=%0d exp n=1 at=8", n_pc, pc_at); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL sw_9cycle_req got=%b exp=1", imem_req); end
    checks++; if (retired !== 4'd2) begin errors++; $display("FAIL sw_retired got=%0d exp=2", retired); end
  endtask

  task automatic test_jal_branch();
    run(JAL, 1, -1, 5);
    checks++; if (n_rf !== 1 || n_pc !== 1) begin errors++; $display("FAIL jal_strobes rf=%0d pc=%0d exp 1 1", n_rf, n_pc); end
    run(BEQ, 1, -1, 5);
    checks++; if (n_rf !== 0 || n_pc !== 1) begin errors++; $display("FAIL beq_strobes rf=%0d pc=%0d exp 0 1", n_rf, n_pc); end
    checks++; if (retired !== 4'd4) begin errors++; $display("FAIL jal_beq_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_ebreak();
    do_reset();
    tick();
    run(BEQ, 1, -1, 5);
    checks++; if (n_rf !== 0 || n_pc !== 1) begin errors++; $display("FAIL eb_beq_strobes rf=%0d pc=%0d exp 0 1", n_rf, n_pc); end
    run(EBREAK, 1, -1, 3);
    checks++; if (iv_at !== 2) begin errors++; $display("FAIL eb_iv_cycle got=%0d exp=2", iv_at); end
    checks++; if ({halt, halt_code} !== 3'b101) begin errors++; $display("FAIL eb_halt got=%b exp=101", {halt, halt_code}); end
    run(ADDI, 0, 0, 20);
    checks++; if (n_ireq + n_iv + n_pc + n_rf + n_dreq !== 0) begin
      errors++; $display("FAIL eb_strobes_quiet got=%0d exp=0", n_ireq + n_iv + n_pc + n_rf + n_dreq); end
    checks++; if ({halt, halt_code} !== 3'b101) begin errors++; $display("FAIL eb_halt_sticky got=%b exp=101", {halt, halt_code}); end
    checks++; if (retired !== 4'd1) begin errors++; $display("FAIL eb_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    run(ADDI, -1, -1, 4);
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL itmo_early got=%b exp=0", halt); end
    run(ADDI, -1, -1, 1);
    checks++; if ({halt, halt_code} !== 3'b110) begin errors++; $display("FAIL itmo_halt got=%b exp=110", {halt, halt_code}); end
    do_reset();
    tick();
    run(ADDI, 4, -1, 8);
    checks++; if (iv_at !== 5 || pc_at !== 7) begin errors++; $display("FAIL itmo_edge iv=%0d pc=%0d exp 5 7", iv_at, pc_at); end
    checks++; if (halt !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL itmo_edge_state halt=%b req=%b exp 0 1", halt, imem_req); end
    do_reset();
    tick();
    run(LW, 1, -1, 9);
    checks++; if ({halt, halt_code} !== 3'b111) begin errors++; $display("FAIL dtmo_halt got=%b exp=111", {halt, halt_code}); end
    checks++; if (n_rf !== 0 || n_pc !== 0) begin errors++; $display("FAIL dtmo_no_wb rf=%0d pc=%0d exp 0 0", n_rf, n_pc); end
    do_reset();
    tick();
    run(LW, 1, 8, 11);
    checks++; if (halt !== 1'b0 || pc_at !== 9 || n_rf !== 1) begin
      errors++; $display("FAIL dtmo_edge halt=%b pc_at=%0d rf=%0d exp 0 9 1", halt, pc_at, n_rf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    run(LW, 1, -1, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0; dmem_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = EBREAK;
    checks++; if ({imem_req, dmem_req, pc_we, rf_we, inst_valid} !== 5'b0) begin
      errors++; $display("FAIL mid_rst_strobes got=%b exp=00000", {imem_req, dmem_req, pc_we, rf_we, inst_valid}); end
    checks++; if (inst !== 32'h13 || retired !== 4'd0) begin
      errors++; $display("FAIL mid_rst_state inst=%h ret=%0d exp 00000013 0", inst, retired); end
    tick();
    checks++; if (imem_req !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL mid_rst_req req=%b rf=%b exp 1 0", imem_req, rf_we); end
    run(ADDI, 1, -1, 5);
    checks++; if (inst !== ADDI || n_rf !== 1 || retired !== 4'd1) begin
      errors++; $display("FAIL mid_rst_resume inst=%h rf=%0d ret=%0d exp %h 1 1", inst, n_rf, retired, ADDI); end
  endtask

  task automatic test_wrap();
    int rf_total;
    rf_total = 0;
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) begin
      run(ADDI, 1, -1, 5);
      rf_total += n_rf;
    end
    checks++; if (retired !== 4'd0) begin errors++; $display("FAIL wrap_16 got=%0d exp=0", retired); end
    run(ADDI, 1, -1, 5);
    rf_total += n_rf;
    checks++; if (retired !== 4'd1) begin errors++; $display("FAIL wrap_17 got=%0d exp=1", retired); end
    checks++; if (rf_total !== 17) begin errors++; $display("FAIL wrap_rf_total got=%0d exp=17", rf_total); end
  endtask

  initial begin
    rst = 1'b1; imem_rvalid = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
    test_reset();
    test_addi();
    test_store();
    test_jal_branch();
    test_ebreak();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
